// File: rtl/axi_pkg.sv
// Shared AXI definitions for the write-drain master.
//  - AXI burst/response encodings
//  - drain FSM state type
//  - clog2 helper used to derive awsize from the data width
package axi_pkg;

  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_RESP
  } drain_state_e;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned i = 1; i < value; i = i << 1) begin
      result++;
    end
    return result;
  endfunction

endpackage

// File: rtl/axi_wr_drain_master.sv
// axi_wr_drain_master
//  Pops words from a write-data buffer and emits them as fixed-length AXI4 INCR
//  write bursts. A job of num_bursts bursts starts at base_addr; one burst is
//  outstanding at a time (AW, then all W beats, then B).
// Ports
//  clk, reset                  clock, synchronous active-high reset
//  start/base_addr/num_bursts  job request (sampled only when idle)
//  busy/done/err               job status (done = 1-cycle pulse, err sticky)
//  buf_empty/buf_data/buf_rd   buffer head interface (pop on buf_rd)
//  aw*/w*/b*                   AXI4 write address, data and response channels
module axi_wr_drain_master
  import axi_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned DATA_WIDTH = 512,
  parameter int unsigned BURST_LEN  = 4,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [ADDR_WIDTH-1:0]   base_addr,
  input  logic [CNT_WIDTH-1:0]    num_bursts,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  input  logic                    buf_empty,
  input  logic [DATA_WIDTH-1:0]   buf_data,
  output logic                    buf_rd,
  output logic [ADDR_WIDTH-1:0]   awaddr,
  output logic [7:0]              awlen,
  output logic [2:0]              awsize,
  output logic [1:0]              awburst,
  output logic                    awvalid,
  input  logic                    awready,
  output logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH/8-1:0] wstrb,
  output logic                    wlast,
  output logic                    wvalid,
  input  logic                    wready,
  input  logic [1:0]              bresp,
  input  logic                    bvalid,
  output logic                    bready
);

  localparam logic [7:0]            AWLEN       = 8'(BURST_LEN - 1);
  localparam logic [2:0]            AWSIZE      = 3'(clog2(DATA_WIDTH / 8));
  localparam logic [ADDR_WIDTH-1:0] BURST_BYTES = ADDR_WIDTH'(BURST_LEN * (DATA_WIDTH / 8));

  drain_state_e           state_q, state_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [CNT_WIDTH-1:0]   left_q, left_d;
  logic [7:0]             beat_q, beat_d;
  logic                   err_q, err_d;
  logic                   done_q, done_d;

  // Only the error bit of BRESP matters (SLVERR/DECERR both flag err).
  logic unused_bresp_lsb;
  assign unused_bresp_lsb = bresp[0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      left_q  <= '0;
      beat_q  <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      left_q  <= left_d;
      beat_q  <= beat_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    left_d  = left_q;
    beat_d  = beat_q;
    err_d   = err_q;
    done_d  = 1'b0;
    awvalid = 1'b0;
    wvalid  = 1'b0;
    wlast   = 1'b0;
    bready  = 1'b0;
    buf_rd  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          addr_d = base_addr;
          left_d = num_bursts;
          beat_d = '0;
          err_d  = 1'b0;
          // An empty job completes immediately without touching the bus.
          if (num_bursts == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = ST_ADDR;
          end
        end
      end
      ST_ADDR: begin
        awvalid = 1'b1;
        if (awready) state_d = ST_DATA;
      end
      ST_DATA: begin
        wvalid = !buf_empty;
        wlast  = (beat_q == AWLEN);
        // Pop only on an accepted beat so a stalled beat keeps wdata stable.
        buf_rd = !buf_empty && wready;
        if (!buf_empty && wready) begin
          if (beat_q == AWLEN) begin
            beat_d  = '0;
            state_d = ST_RESP;
          end else begin
            beat_d = beat_q + 8'd1;
          end
        end
      end
      ST_RESP: begin
        bready = 1'b1;
        if (bvalid) begin
          err_d  = err_q | bresp[1];
          addr_d = addr_q + BURST_BYTES;
          left_d = left_q - CNT_WIDTH'(1);
          if (left_q == CNT_WIDTH'(1)) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_ADDR;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy    = (state_q != ST_IDLE);
  assign done    = done_q;
  assign err     = err_q;
  assign awaddr  = addr_q;
  assign awlen   = AWLEN;
  assign awsize  = AWSIZE;
  assign awburst = AXI_BURST_INCR;
  assign wdata   = buf_data;
  assign wstrb   = '1;

endmodule

// File: tb/tb_axi_wr_drain_master.sv
// Scoreboard bench for axi_wr_drain_master: stimulus pushes expected AW
// addresses, W beats and job completions; a negedge monitor pops and compares.
module tb_axi_wr_drain_master;

  localparam int unsigned AW = 64;
  localparam int unsigned DW = 512;
  localparam int unsigned BL = 4;
  localparam int unsigned CW = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic [AW-1:0]   base_addr;
  logic [CW-1:0]   num_bursts;
  logic            busy, done, err;
  logic            buf_empty;
  logic [DW-1:0]   buf_data;
  logic            buf_rd;
  logic [AW-1:0]   awaddr;
  logic [7:0]      awlen;
  logic [2:0]      awsize;
  logic [1:0]      awburst;
  logic            awvalid, awready;
  logic [DW-1:0]   wdata;
  logic [DW/8-1:0] wstrb;
  logic            wlast, wvalid;
  logic            wready = 1'b1;
  logic [1:0]      bresp = 2'b00;
  logic            bvalid = 1'b0;
  logic            bready;

  always #5 clk = ~clk;

  axi_wr_drain_master #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_LEN(BL), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .num_bursts(num_bursts), .busy(busy), .done(done), .err(err),
    .buf_empty(buf_empty), .buf_data(buf_data), .buf_rd(buf_rd),
    .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready), .wdata(wdata), .wstrb(wstrb),
    .wlast(wlast), .wvalid(wvalid), .wready(wready), .bresp(bresp),
    .bvalid(bvalid), .bready(bready)
  );

  // ---------------- buffer model ----------------
  logic [DW-1:0] mem [64];
  logic [5:0]    wr_ptr = '0;
  logic [5:0]    rd_ptr = '0;
  assign buf_empty = (rd_ptr == wr_ptr);
  assign buf_data  = mem[rd_ptr];
  always @(posedge clk) if (buf_rd) rd_ptr <= rd_ptr + 6'd1;

  // ---------------- slave model ----------------
  logic wr_rand = 1'b0;
  int   b_delay = 0;
  int   b_wait  = 0;
  int   b_num   = 0;
  int   err_on_b = -1;
  logic b_pend  = 1'b0;

  always @(posedge clk) wready <= wr_rand ? 1'($urandom_range(0, 1)) : 1'b1;

  always @(posedge clk) begin
    if (reset) begin
      bvalid <= 1'b0;
      b_pend <= 1'b0;
    end else begin
      if (bvalid && bready) begin
        bvalid <= 1'b0;
        b_num  <= b_num + 1;
      end
      if (wvalid && wready && wlast) begin
        b_pend <= 1'b1;
        b_wait <= b_delay;
      end else if (b_pend && !bvalid) begin
        if (b_wait == 0) begin
          bvalid <= 1'b1;
          bresp  <= (b_num == err_on_b) ? 2'b10 : 2'b00;
          b_pend <= 1'b0;
        end else begin
          b_wait <= b_wait - 1;
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct { logic [DW-1:0] data; logic last; } wexp_t;
  logic [AW-1:0] exp_aw[$];
  wexp_t         exp_w[$];
  logic          exp_done[$];

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s: event occurred/expired, required otherwise", name);
  endtask

  initial begin
    logic          aw_open = 1'b0;
    logic          prev_stall = 1'b0;
    logic          prev_done = 1'b0;
    logic [DW-1:0] prev_wdata = '0;
    wexp_t         we;
    forever begin
      @(negedge clk);
      if (reset) begin
        aw_open = 1'b0; prev_stall = 1'b0; prev_done = 1'b0;
      end else begin
        chk("buf_rd_only_on_handshake", buf_rd, wvalid & wready);
        if (buf_empty) chk("no_wvalid_when_empty", wvalid, 0);
        if (prev_stall) begin
          chk("stall_wvalid_held", wvalid, 1);
          chk("stall_wdata_stable", wdata, prev_wdata);
        end
        if (awvalid && awready) begin
          chk("aw_after_prior_b", aw_open, 0);
          if (exp_aw.size() == 0) fail("unexpected_aw");
          else begin
            chk("awaddr", awaddr, exp_aw.pop_front());
            chk("awlen", awlen, 3);
            chk("awsize", awsize, 6);
            chk("awburst", awburst, 1);
            chk("wstrb", wstrb, {(DW/8){1'b1}});
          end
          aw_open = 1'b1;
        end
        if (wvalid && wready) begin
          chk("w_inside_open_burst", aw_open, 1);
          if (exp_w.size() == 0) fail("unexpected_w_beat");
          else begin
            we = exp_w.pop_front();
            chk("wdata", wdata, we.data);
            chk("wlast", wlast, we.last);
          end
        end
        if (bvalid && bready) aw_open = 1'b0;
        if (done) begin
          chk("busy_low_at_done", busy, 0);
          chk("done_single_cycle", prev_done, 0);
          if (exp_done.size() == 0) fail("unexpected_done");
          else chk("err_at_done", err, exp_done.pop_front());
          done_cnt++;
        end
        prev_stall = wvalid & !wready;
        prev_wdata = wdata;
        prev_done  = done;
      end
    end
  end

  // ---------------- stimulus ----------------
  int word_idx = 0;
  int job_beat = 0;

  function automatic logic [DW-1:0] word(input int i);
    return {8{64'hC0DE_0000_0000_0000 | 64'(i)}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word();
    mem[wr_ptr] = word(word_idx);
    exp_w.push_back('{data: word(word_idx), last: ((job_beat % BL) == BL - 1)});
    word_idx++;
    job_beat++;
    wr_ptr = wr_ptr + 6'd1;
  endtask

  task automatic do_start(input logic [AW-1:0] b, input int n, input bit lat_chk);
    start = 1'b1; base_addr = b; num_bursts = CW'(n);
    tick();
    start = 1'b0;
    if (lat_chk) begin
      @(negedge clk);
      if (n == 0) begin
        chk("zero_job_done_next_cycle", done, 1);
        chk("zero_job_busy", busy, 0);
        chk("zero_job_no_awvalid", awvalid, 0);
      end else begin
        chk("start_to_awvalid", awvalid, 1);
        chk("busy_after_start", busy, 1);
      end
    end
  endtask

  task automatic wait_done(input int d0, input int max_cycles);
    int i;
    for (i = 0; i < max_cycles && done_cnt == d0; i++) tick();
    if (done_cnt == d0) fail("done_timeout");
    chk("scoreboard_drained", exp_aw.size() + exp_w.size() + exp_done.size(), 0);
  endtask

  initial begin
    int d0;
    reset = 1'b1; start = 1'b0; base_addr = '0; num_bursts = '0; awready = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    @(negedge clk);
    chk("reset_outputs", {busy, done, err, buf_rd, awvalid, wvalid, wlast, bready}, 0);

    // T1: reset while stalled at beat 2 of 4
    job_beat = 0;
    exp_aw.push_back(64'h1000);
    push_word(); push_word();
    do_start(64'h1000, 2, 1'b1);
    repeat (10) tick();
    @(negedge clk);
    chk("t1_stalled_busy", busy, 1);
    chk("t1_stalled_no_pop", {awvalid, wvalid, buf_rd}, 0);
    tick();
    reset = 1'b1;
    tick();
    @(negedge clk);
    chk("t1_reset_outputs", {busy, done, err, buf_rd, awvalid, wvalid, wlast, bready}, 0);
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("t1_after_reset_idle", {busy, buf_rd, awvalid}, 0);
    chk("t1_scoreboard", exp_aw.size() + exp_w.size(), 0);
    tick();

    // T2: two bursts from preloaded buffer
    job_beat = 0; d0 = done_cnt;
    exp_aw.push_back(64'h1000); exp_aw.push_back(64'h1100);
    repeat (8) push_word();
    exp_done.push_back(1'b0);
    do_start(64'h1000, 2, 1'b1);
    wait_done(d0, 200);

    // T3: buffer trickle-fed, one word every 3 cycles
    job_beat = 0; d0 = done_cnt;
    exp_aw.push_back(64'h2000); exp_aw.push_back(64'h2100);
    exp_done.push_back(1'b0);
    do_start(64'h2000, 2, 1'b1);
    for (int i = 0; i < 8; i++) begin
      repeat (3) tick();
      push_word();
    end
    wait_done(d0, 200);

    // T4: random wready, B delayed 5 cycles
    wr_rand = 1'b1; b_delay = 5;
    job_beat = 0; d0 = done_cnt;
    exp_aw.push_back(64'h4000); exp_aw.push_back(64'h4100); exp_aw.push_back(64'h4200);
    repeat (12) push_word();
    exp_done.push_back(1'b0);
    do_start(64'h4000, 3, 1'b1);
    wait_done(d0, 500);
    wr_rand = 1'b0; b_delay = 0;
    tick();

    // T5: SLVERR on second response; job continues, err sticky, next start clears
    job_beat = 0; d0 = done_cnt;
    err_on_b = b_num + 1;
    exp_aw.push_back(64'h5000); exp_aw.push_back(64'h5100); exp_aw.push_back(64'h5200);
    repeat (12) push_word();
    exp_done.push_back(1'b1);
    do_start(64'h5000, 3, 1'b1);
    wait_done(d0, 300);
    err_on_b = -1;
    repeat (3) tick();
    @(negedge clk);
    chk("t5_err_sticky", err, 1);
    tick();

    // T6a: empty job clears err, done next cycle, no AXI activity
    d0 = done_cnt;
    exp_done.push_back(1'b0);
    do_start(64'h6000, 0, 1'b1);
    tick();
    @(negedge clk);
    chk("t6_err_cleared", err, 0);
    chk("t6_zero_job_count", done_cnt, d0 + 1);
    tick();

    // T6b: start while busy is ignored
    job_beat = 0; d0 = done_cnt;
    exp_aw.push_back(64'h8000); exp_aw.push_back(64'h8100);
    repeat (8) push_word();
    exp_done.push_back(1'b0);
    do_start(64'h8000, 2, 1'b1);
    repeat (3) tick();
    do_start(64'hDEAD_0000, 5, 1'b0);
    wait_done(d0, 200);
    repeat (20) tick();
    @(negedge clk);
    chk("t6_ignored_start_no_job", {busy, awvalid}, 0);
    tick();

    // T6c: address wrap at top of address space
    job_beat = 0; d0 = done_cnt;
    exp_aw.push_back(64'hFFFF_FFFF_FFFF_FF00); exp_aw.push_back(64'h0);
    repeat (8) push_word();
    exp_done.push_back(1'b0);
    do_start(64'hFFFF_FFFF_FFFF_FF00, 2, 1'b1);
    wait_done(d0, 200);

    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    fail("global_timeout");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "simulation time limit reached");
  end

endmodule
